dma_axi_wr_slave: RTL
=====================

# dma_axi_wr_slave

AXI4 write-channel responder that terminates the DMA controller's memory-side AXI4 write master and drives a single-port SRAM-style write interface. It accepts one INCR or FIXED burst at a time on AW/W, converts each accepted beat into a memory write, and returns a single B response per burst. It is the write-side target used behind the DMA in subsystem integration and as the bench memory for DMA regression.

## Interface
- ADDR_W, 32, address width (from dma_pkg)
- DATA_W, 32, data width; byte lanes STRB_W = DATA_W/8
- ID_W, 4, AXI ID width
- MEM_BASE, 32'h8000_0000, first byte address of the target window
- MEM_BYTES, 65536, window size in bytes (power of two)

- clk_i  in  1  clock
- rst_ni  in  1  synchronous, active-low reset
- s_axi_awid_i  in  ID_W  write ID
- s_axi_awaddr_i  in  ADDR_W  burst start byte address
- s_axi_awlen_i  in  8  beats minus one
- s_axi_awsize_i  in  3  log2 bytes per beat
- s_axi_awburst_i  in  2  00 FIXED, 01 INCR, 10 WRAP
- s_axi_awvalid_i / s_axi_awready_o  in/out  1  AW handshake
- s_axi_wdata_i  in  DATA_W  write data
- s_axi_wstrb_i  in  STRB_W  byte strobes
- s_axi_wlast_i  in  1  last beat marker
- s_axi_wvalid_i / s_axi_wready_o  in/out  1  W handshake
- s_axi_bid_o  out  ID_W  response ID (= latched awid)
- s_axi_bresp_o  out  2  00 OKAY, 10 SLVERR, 11 DECERR
- s_axi_bvalid_o / s_axi_bready_i  out/in  1  B handshake
- mem_we_o  out  1  memory write strobe
- mem_addr_o  out  ADDR_W  word-aligned offset from MEM_BASE
- mem_wdata_o  out  DATA_W  write data (pass-through)
- mem_wstrb_o  out  STRB_W  byte enables (pass-through)
- mem_ready_i  in  1  memory can accept a write this cycle

## Operation
- States: IDLE, DATA, RESP. Reset → IDLE.
- IDLE: awready_o=1. On awvalid&awready latch id, addr, len, size, burst; clear beat counter; compute error class; → DATA.
- Error class at AW: awburst=WRAP or reserved, or awsize > log2(STRB_W) → SLVERR; start or end address (start + ((len+1)<<size) − 1) outside [MEM_BASE, MEM_BASE+MEM_BYTES) → DECERR. DECERR takes priority. Errored bursts still consume all W beats; mem_we_o never asserted for them.
- DATA: wready_o = mem_ready_i. Beat handshake = wvalid&wready. mem_we_o = handshake & no-error, combinational in same cycle; mem_addr_o = current address − MEM_BASE, low log2(STRB_W) bits zeroed. Strobes passed unmodified.
- Address update per beat: INCR adds 1<<size (ADDR_W wrap-around arithmetic); FIXED holds.
- Beat counter 9 bits; burst ends on beat len+1 regardless of wlast. wlast on any other beat, or wlast low on final beat → sticky SLVERR (unless already DECERR); early wlast does not terminate.
- RESP: bvalid_o=1, bid/bresp stable until bready; on handshake → IDLE. awready_o=0 and wready_o=0 outside their states: one outstanding burst only.

## Timing
- Reset values: awready_o 1 (IDLE), wready_o 0, bvalid_o 0, bresp_o 00, bid_o 0, mem_we_o 0, mem_addr_o 0.
- Reset asserted mid-burst: next edge → IDLE, latched burst and sticky error discarded, no B issued.
- AW handshake cycle N → wready_o may assert cycle N+1; W in same cycle as AW is not accepted.
- Final beat handshake cycle M → bvalid_o at M+1; bready high at M+1 → awready_o at M+2.
- Full throughput: len+1 beats in len+1 consecutive cycles with mem_ready_i and wvalid held high.
- mem_ready_i low stalls wready_o the same cycle; no beat lost or duplicated.

## Structure
- dma_pkg gains: axi_burst_e, axi_resp_e, wr_slv_state_e, and AXI_SIZE_MAX derivation helper.
- One sub-module: dma_axi_addr_gen (latched address, size, burst type → next address and range check), reusable by a later read-side responder.

## Test plan
- INCR awaddr 0x8000_0100, len 3, size 2, data 0xA0..0xA3 → mem writes at 0x100,0x104,0x108,0x10C on 4 consecutive cycles, BRESP OKAY, BID = AWID, bvalid one cycle after last beat.
- FIXED awaddr 0x8000_0040, len 7 → 8 writes all at 0x040, OKAY.
- INCR awaddr 0x8000_FFF8, len 3, size 2 → no mem_we_o, 4 beats accepted, BRESP DECERR; awburst WRAP → SLVERR, no writes.
- mem_ready_i toggled 1,0,0,1 during len 3 burst and bready held low 5 cycles after last beat → exactly 4 writes, bvalid/bresp stable until bready, awready low throughout.
- wlast on beat 2 of len 3 → 4 writes still performed, BRESP SLVERR; rst_ni low for one cycle mid-burst → IDLE, awready 1, no bvalid.

Source files
------------

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared DMA types, widths and helpers
// Purpose: AXI burst/response encodings, write-responder FSM states,
//          default bus widths and the max-beat-size helper.
// Ports:   none (package)
package dma_pkg;

    localparam int DMA_ADDR_W = 32;
    localparam int DMA_DATA_W = 32;
    localparam int DMA_ID_W   = 4;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } axi_burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DATA = 2'b01,
        ST_RESP = 2'b10
    } wr_slv_state_e;

    // Largest legal AxSIZE for a bus with strb_w byte lanes.
    function automatic logic [2:0] axi_size_max(input int strb_w);
        return 3'($clog2(strb_w));
    endfunction

endpackage

// File: rtl/dma_axi_addr_gen.sv
// rtl/dma_axi_addr_gen.sv - AXI beat address stepping and window range check
// Purpose: next-beat address from the latched burst state, and a check that
//          a whole burst (start .. start+((len+1)<<size)-1) fits the window.
// Ports:   i_cur_addr/i_cur_size/i_cur_burst -> o_next_addr
//          i_start_addr/i_len/i_size         -> o_in_range
module dma_axi_addr_gen
    import dma_pkg::*;
#(
    parameter int                ADDR_W    = DMA_ADDR_W,
    parameter logic [ADDR_W-1:0] MEM_BASE  = 32'h8000_0000,
    parameter int                MEM_BYTES = 65536
) (
    input  logic [ADDR_W-1:0] i_cur_addr,
    input  logic [2:0]        i_cur_size,
    input  axi_burst_e        i_cur_burst,
    output logic [ADDR_W-1:0] o_next_addr,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic [7:0]        i_len,
    input  logic [2:0]        i_size,
    output logic              o_in_range
);

    // One extra bit so the window end and burst end never wrap.
    localparam logic [ADDR_W:0] LP_LO  = {1'b0, MEM_BASE};
    localparam logic [ADDR_W:0] LP_HI  = LP_LO + (ADDR_W+1)'(MEM_BYTES);
    localparam logic [ADDR_W:0] LP_ONE = (ADDR_W+1)'(1);

    logic [ADDR_W-1:0] w_step;
    logic [8:0]        w_beats;
    logic [ADDR_W:0]   w_bytes;
    logic [ADDR_W:0]   w_end;

    assign w_step      = {{(ADDR_W-1){1'b0}}, 1'b1} << i_cur_size;
    assign o_next_addr = (i_cur_burst == BURST_INCR) ? (i_cur_addr + w_step) : i_cur_addr;

    assign w_beats    = {1'b0, i_len} + 9'd1;
    assign w_bytes    = {{(ADDR_W-8){1'b0}}, w_beats} << i_size;
    assign w_end      = {1'b0, i_start_addr} + w_bytes - LP_ONE;
    assign o_in_range = ({1'b0, i_start_addr} >= LP_LO) && (w_end < LP_HI);

endmodule

// File: rtl/dma_axi_wr_slave.sv
// rtl/dma_axi_wr_slave.sv - AXI4 write responder driving an SRAM-style write port
// Purpose: accepts one FIXED/INCR burst at a time, turns each W beat into a
//          memory write and returns one B response per burst.
// Ports:   clk_i, rst_ni (sync, active-low)
//          s_axi_aw* : burst request       s_axi_w* : write beats
//          s_axi_b*  : burst response      mem_*    : memory write port
module dma_axi_wr_slave
    import dma_pkg::*;
#(
    parameter int                ADDR_W    = DMA_ADDR_W,
    parameter int                DATA_W    = DMA_DATA_W,
    parameter int                ID_W      = DMA_ID_W,
    parameter logic [ADDR_W-1:0] MEM_BASE  = 32'h8000_0000,
    parameter int                MEM_BYTES = 65536,
    parameter int                STRB_W    = DATA_W/8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ID_W-1:0]   s_axi_awid_i,
    input  logic [ADDR_W-1:0] s_axi_awaddr_i,
    input  logic [7:0]        s_axi_awlen_i,
    input  logic [2:0]        s_axi_awsize_i,
    input  logic [1:0]        s_axi_awburst_i,
    input  logic              s_axi_awvalid_i,
    output logic              s_axi_awready_o,
    input  logic [DATA_W-1:0] s_axi_wdata_i,
    input  logic [STRB_W-1:0] s_axi_wstrb_i,
    input  logic              s_axi_wlast_i,
    input  logic              s_axi_wvalid_i,
    output logic              s_axi_wready_o,
    output logic [ID_W-1:0]   s_axi_bid_o,
    output logic [1:0]        s_axi_bresp_o,
    output logic              s_axi_bvalid_o,
    input  logic              s_axi_bready_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [STRB_W-1:0] mem_wstrb_o,
    input  logic              mem_ready_i
);

    localparam int LSB_W = $clog2(STRB_W);

    wr_slv_state_e     r_state;
    logic              r_awready;
    logic              r_bvalid;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [2:0]        r_size;
    axi_burst_e        r_burst;
    logic [8:0]        r_cnt;
    axi_resp_e         r_resp;
    logic              r_aw_err;    // burst rejected at AW: suppress all memory writes

    logic              w_aw_hs;
    logic              w_wready;
    logic              w_w_hs;
    logic              w_last_beat;
    logic              w_aw_slverr;
    logic              w_in_range;
    logic [ADDR_W-1:0] w_next_addr;
    logic [ADDR_W-1:0] w_offset;

    dma_axi_addr_gen #(
        .ADDR_W    (ADDR_W),
        .MEM_BASE  (MEM_BASE),
        .MEM_BYTES (MEM_BYTES)
    ) u_addr_gen (
        .i_cur_addr   (r_addr),
        .i_cur_size   (r_size),
        .i_cur_burst  (r_burst),
        .o_next_addr  (w_next_addr),
        .i_start_addr (s_axi_awaddr_i),
        .i_len        (s_axi_awlen_i),
        .i_size       (s_axi_awsize_i),
        .o_in_range   (w_in_range)
    );

    assign w_aw_hs     = s_axi_awvalid_i & r_awready;
    assign w_wready    = (r_state == ST_DATA) & mem_ready_i;
    assign w_w_hs      = s_axi_wvalid_i & w_wready;
    assign w_last_beat = (r_cnt == {1'b0, r_len});
    assign w_aw_slverr = ((s_axi_awburst_i != BURST_INCR) && (s_axi_awburst_i != BURST_FIXED))
                       || (s_axi_awsize_i > axi_size_max(STRB_W));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_awready <= 1'b1;
            r_bvalid  <= 1'b0;
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_burst   <= BURST_FIXED;
            r_cnt     <= '0;
            r_resp    <= RESP_OKAY;
            r_aw_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_aw_hs) begin
                        r_id      <= s_axi_awid_i;
                        r_addr    <= s_axi_awaddr_i;
                        r_len     <= s_axi_awlen_i;
                        r_size    <= s_axi_awsize_i;
                        r_burst   <= axi_burst_e'(s_axi_awburst_i);
                        r_cnt     <= '0;
                        r_aw_err  <= !w_in_range || w_aw_slverr;
                        r_resp    <= !w_in_range ? RESP_DECERR :
                                     (w_aw_slverr ? RESP_SLVERR : RESP_OKAY);
                        r_awready <= 1'b0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_w_hs) begin
                        r_cnt  <= r_cnt + 9'd1;
                        r_addr <= w_next_addr;
                        // Misplaced or missing wlast is sticky but never ends the burst early.
                        if ((s_axi_wlast_i != w_last_beat) && (r_resp != RESP_DECERR))
                            r_resp <= RESP_SLVERR;
                        if (w_last_beat) begin
                            r_bvalid <= 1'b1;
                            r_state  <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (s_axi_bready_i) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_offset = r_addr - MEM_BASE;

    assign s_axi_awready_o = r_awready;
    assign s_axi_wready_o  = w_wready;
    assign s_axi_bvalid_o  = r_bvalid;
    assign s_axi_bid_o     = r_id;
    assign s_axi_bresp_o   = r_bvalid ? r_resp : RESP_OKAY;

    assign mem_we_o    = w_w_hs & !r_aw_err;
    assign mem_addr_o  = (r_state == ST_DATA) ? {w_offset[ADDR_W-1:LSB_W], {LSB_W{1'b0}}} : '0;
    assign mem_wdata_o = s_axi_wdata_i;
    assign mem_wstrb_o = s_axi_wstrb_i;

endmodule
